alu_multicycle: RTL and testbench
=================================

# alu_multicycle

Parametrised, registered ALU that replaces the fixed 16-bit combinational ALU in the MISC-V datapath. It adds a Start/Busy/Done handshake, shift and XOR operations, full condition flags, and an iterative shift-add multiplier that occupies the unit for WIDTH cycles. The control unit issues one operation at a time. Results and flags are held until the next operation completes.

## Interface
- WIDTH, 16: operand and result width. Must be a power of two, at least 4.
- SHW, $clog2(WIDTH): shift-amount width. Derived; do not override.
- CLK  in  1  clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  request; sampled only while Busy=0.
- ALUOp  in  4  operation code; sampled with Start.
- FirstInput  in  WIDTH  operand A; sampled with Start.
- SecondInput  in  WIDTH  operand B; sampled with Start.
- Busy  out  1  a multi-cycle operation is in progress.
- Done  out  1  one-cycle pulse; OutputData and flags are updated this cycle.
- OutputData  out  WIDTH  registered result.
- Zero  out  1  OutputData == 0.
- Negative  out  1  OutputData[WIDTH-1].
- Carry  out  1  carry/no-borrow flag (see Operation).
- Overflow  out  1  signed overflow flag.

## Operation
- Opcodes:
  - 0 NOP, 1 ADD, 2 SUB, 3 OR, 4 AND, 5 XOR, 6 SLL, 7 SRL, 8 SRA, 9 MUL.
  - 10–15 execute as NOP.
  - Codes 0–4 keep the existing ALU encoding.
- NOP: result 0, Zero=1, Carry=Overflow=0.
- ADD: result A+B mod 2^WIDTH. Carry = unsigned carry-out. Overflow = sign(A)==sign(B) and sign(result)!=sign(A).
- SUB: result A−B mod 2^WIDTH. Carry = 1 when A ≥ B unsigned (no borrow). Overflow = sign(A)!=sign(B) and sign(result)!=sign(A).
- OR / AND / XOR: bitwise. Carry=Overflow=0.
- Shifts:
  - Amount is SecondInput[SHW-1:0]; upper bits of SecondInput are ignored.
  - SLL and SRL zero-fill; SRA sign-fills.
  - Carry = last bit shifted out, or 0 when the amount is 0. Overflow=0.
- MUL:
  - Unsigned shift-add, one partial product per cycle.
  - Result = low WIDTH bits of A×B. Carry = 1 if any of the high WIDTH bits is nonzero. Overflow=0.
- Zero and Negative always follow the new OutputData.
- Operands and opcode are captured at acceptance; input changes while Busy=1 are ignored.
- Start while Busy=1 is ignored and is not queued.
- Outputs hold their value between Done pulses.
- Reset, including mid-MUL: Busy=0, Done=0, OutputData=0, Zero=1, Negative=0, Carry=0, Overflow=0. Any in-flight MUL is discarded.
- Internal FSM:
  - IDLE → IDLE on a single-cycle op (result written at the accepting edge).
  - IDLE → MUL on opcode 9, with iteration counter = 0.
  - MUL → MUL while counter < WIDTH−1.
  - MUL → IDLE on the final iteration, writing the result.

## Timing
- Single-cycle ops: Start accepted at edge k. OutputData, flags and Done=1 are valid after edge k. Done drops after edge k+1 unless a new op completes then. Latency is 1.
- MUL: accepted at edge k, Busy=1 after edge k. Iterations occur at edges k+1 … k+WIDTH. Result, flags and Done=1 appear after edge k+WIDTH, and Busy=0 after that same edge. Latency is WIDTH+1.
- Back-to-back issue: Start is accepted in the cycle Done is high, because Busy is already 0. Throughput is 1 op/cycle for single-cycle ops and 1 op per WIDTH+1 cycles for MUL.
- Reset assertion takes effect immediately, without waiting for a clock edge. The first Start is accepted at the first edge after reset deassertion.

## Structure
- Shared package alu_pkg:
  - Opcode localparams ALU_NOP … ALU_MUL.
  - FSM state encodings ST_IDLE and ST_MUL.
  - Opcode width constant ALU_OP_W = 4.
- Sub-module alu_mul_iter(WIDTH):
  - Holds the multiplicand, multiplier and accumulator registers and the iteration counter.
  - Interface: Load, Step, Product[2*WIDTH-1:0], Last.
  - The top level owns the handshake, the single-cycle datapath and the output/flag registers.

## Test plan
- Reset with WIDTH=16, then Start ADD 1+1 → after one edge: OutputData=2, Zero=0, Done=1 for exactly 1 cycle. Assert Reset mid-MUL on the next op → all outputs return to reset values at once.
- ADD 0x7FFF+1 → 0x8000, Overflow=1, Negative=1. ADD 0xFFFF+1 → 0, Carry=1, Zero=1.
- SUB with A=15, B=28 → 0xFFF3 (−13), Carry=0. SUB with A=0xFFFD, B=0xFFFB → 2, Carry=1. SUB with A=1, B=1 → Zero=1.
- Shifts:
  - SRA 0x8001 by 1 → 0xC000, Carry=1.
  - SLL 1 by SecondInput=0x0013 (amount 3) → 8.
  - SRL 0x8000 by 15 → 1.
- MUL 300×300:
  - Busy high for 16 cycles, then Done with OutputData=0x5F90 and Carry=1.
  - Start pulses and operand changes during Busy have no effect.
- Back-to-back: ADD issued in the cycle MUL's Done is high → ADD result appears one edge later. Opcodes 10–15 → OutputData=0, Zero=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode, width and FSM definitions for the multi-cycle ALU.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

  localparam int ALU_OP_W = 4;

  // Codes 0-4 match the original combinational ALU encoding.
  localparam logic [ALU_OP_W-1:0] ALU_NOP = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'd5;
  localparam logic [ALU_OP_W-1:0] ALU_SLL = 4'd6;
  localparam logic [ALU_OP_W-1:0] ALU_SRL = 4'd7;
  localparam logic [ALU_OP_W-1:0] ALU_SRA = 4'd8;
  localparam logic [ALU_OP_W-1:0] ALU_MUL = 4'd9;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier, one partial product per Step.
// Latency: WIDTH Steps after Load; Product includes the current Step's partial product.
// Backpressure: none; the caller sequences Load/Step and watches Last.
// Ports: Load captures Multiplicand/Multiplier and clears the accumulator and counter;
//        Step adds one partial product; Product is the accumulator after this Step;
//        Last flags that the current Step is the final one.
module alu_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic               Load,
  input  logic               Step,
  input  logic [WIDTH-1:0]   Multiplicand,
  input  logic [WIDTH-1:0]   Multiplier,
  output logic [2*WIDTH-1:0] Product,
  output logic               Last
);

  localparam int SHW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]     cnt_q, cnt_d;

  // Partial product is selected by the multiplier LSB, which is shifted
  // right each Step while the multiplicand moves left.
  assign Product = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign Last    = (cnt_q == SHW'(WIDTH - 1));

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (Load) begin
      mcand_d  = {{WIDTH{1'b0}}, Multiplicand};
      mplier_d = Multiplier;
      acc_d    = '0;
      cnt_d    = '0;
    end else if (Step) begin
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      acc_d    = Product;
      cnt_d    = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Registered ALU with Start/Busy/Done handshake; single-cycle ops plus an iterative MUL.
// Latency: 1 edge for single-cycle ops, WIDTH+1 edges for MUL.
// Backpressure: Start is ignored (not queued) while Busy=1.
// Ports: Start/ALUOp/FirstInput/SecondInput sampled when Busy=0; Done pulses for one
//        cycle with new OutputData and flags (Zero, Negative, Carry, Overflow), held after.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic                Start,
  input  logic [ALU_OP_W-1:0] ALUOp,
  input  logic [WIDTH-1:0]    FirstInput,
  input  logic [WIDTH-1:0]    SecondInput,
  output logic                Busy,
  output logic                Done,
  output logic [WIDTH-1:0]    OutputData,
  output logic                Zero,
  output logic                Negative,
  output logic                Carry,
  output logic                Overflow
);

  alu_state_t state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic carry_q, carry_d;
  logic ovf_q, ovf_d;
  logic done_q, done_d;

  logic mul_load, mul_step, mul_last;
  logic [2*WIDTH-1:0] mul_prod;

  // Single-cycle datapath
  logic [WIDTH-1:0] sc_res;
  logic sc_carry, sc_ovf;
  logic [SHW-1:0] amt;
  logic [WIDTH:0] add_w, sub_w, sll_w, srl_w;
  logic signed [WIDTH:0] sra_w;

  assign amt = SecondInput[SHW-1:0];

  // Shifts run on a WIDTH+1 vector so the last bit shifted out lands in the
  // extra bit position; with amount 0 that bit is the zero/appended fill.
  always_comb begin
    add_w = {1'b0, FirstInput} + {1'b0, SecondInput};
    sub_w = {1'b0, FirstInput} - {1'b0, SecondInput};
    sll_w = {1'b0, FirstInput} << amt;
    srl_w = {FirstInput, 1'b0} >> amt;
    sra_w = $signed({FirstInput, 1'b0}) >>> amt;

    sc_res   = '0;
    sc_carry = 1'b0;
    sc_ovf   = 1'b0;
    case (ALUOp)
      ALU_ADD: begin
        sc_res   = add_w[WIDTH-1:0];
        sc_carry = add_w[WIDTH];
        sc_ovf   = (FirstInput[WIDTH-1] == SecondInput[WIDTH-1]) &&
                   (add_w[WIDTH-1] != FirstInput[WIDTH-1]);
      end
      ALU_SUB: begin
        sc_res   = sub_w[WIDTH-1:0];
        sc_carry = ~sub_w[WIDTH];  // top bit is the borrow
        sc_ovf   = (FirstInput[WIDTH-1] != SecondInput[WIDTH-1]) &&
                   (sub_w[WIDTH-1] != FirstInput[WIDTH-1]);
      end
      ALU_OR:  sc_res = FirstInput | SecondInput;
      ALU_AND: sc_res = FirstInput & SecondInput;
      ALU_XOR: sc_res = FirstInput ^ SecondInput;
      ALU_SLL: begin
        sc_res   = sll_w[WIDTH-1:0];
        sc_carry = sll_w[WIDTH];
      end
      ALU_SRL: begin
        sc_res   = srl_w[WIDTH:1];
        sc_carry = srl_w[0];
      end
      ALU_SRA: begin
        sc_res   = sra_w[WIDTH:1];
        sc_carry = sra_w[0];
      end
      default: ;  // NOP and codes 10-15 give result 0, flags 0
    endcase
  end

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .CLK          (CLK),
    .Reset        (Reset),
    .Load         (mul_load),
    .Step         (mul_step),
    .Multiplicand (FirstInput),
    .Multiplier   (SecondInput),
    .Product      (mul_prod),
    .Last         (mul_last)
  );

  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    mul_load = 1'b0;
    mul_step = 1'b0;
    if (state_q == ST_IDLE) begin
      if (Start) begin
        if (ALUOp == ALU_MUL) begin
          mul_load = 1'b1;
          state_d  = ST_MUL;
        end else begin
          res_d   = sc_res;
          carry_d = sc_carry;
          ovf_d   = sc_ovf;
          done_d  = 1'b1;
        end
      end
    end else begin
      mul_step = 1'b1;
      if (mul_last) begin
        state_d = ST_IDLE;
        res_d   = mul_prod[WIDTH-1:0];
        carry_d = |mul_prod[2*WIDTH-1:WIDTH];
        ovf_d   = 1'b0;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      res_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign Busy       = (state_q == ST_MUL);
  assign Done       = done_q;
  assign OutputData = res_q;
  assign Zero       = (res_q == '0);
  assign Negative   = res_q[WIDTH-1];
  assign Carry      = carry_q;
  assign Overflow   = ovf_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle (WIDTH=16): directed vectors plus random ops.
// Latency: checks 1 edge for single-cycle ops, 16 Busy edges then Done for MUL.
// Backpressure: drives Start noise while Busy to confirm it is ignored.
module tb_alu_multicycle;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        Start;
  logic [3:0]  ALUOp;
  logic [15:0] FirstInput, SecondInput;
  logic        Busy, Done, Zero, Negative, Carry, Overflow;
  logic [15:0] OutputData;

  int checks = 0;
  int errors = 0;

  alu_multicycle #(.WIDTH(16)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .ALUOp(ALUOp),
    .FirstInput(FirstInput), .SecondInput(SecondInput),
    .Busy(Busy), .Done(Done), .OutputData(OutputData),
    .Zero(Zero), .Negative(Negative), .Carry(Carry), .Overflow(Overflow)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model straight from the opcode definitions, using plain integer arithmetic.
  function automatic void ref_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                 output logic [15:0] r, output logic c, output logic v);
    longint s;
    int n;
    n = int'(b[3:0]);
    r = '0; c = 1'b0; v = 1'b0;
    case (op)
      4'd1: begin
        s = longint'(a) + longint'(b);
        r = s[15:0]; c = (s >= 65536);
        v = (a[15] == b[15]) && (r[15] != a[15]);
      end
      4'd2: begin
        s = longint'(a) - longint'(b);
        r = s[15:0]; c = (a >= b);
        v = (a[15] != b[15]) && (r[15] != a[15]);
      end
      4'd3: r = a | b;
      4'd4: r = a & b;
      4'd5: r = a ^ b;
      4'd6: begin
        s = longint'(a) * (longint'(1) << n);
        r = s[15:0]; c = (n == 0) ? 1'b0 : ((s / 65536) % 2 == 1);
      end
      4'd7: begin
        r = a / (16'd1 << n); c = (n == 0) ? 1'b0 : a[n-1];
      end
      4'd8: begin
        s = longint'($signed(a)) >>> n;
        r = s[15:0]; c = (n == 0) ? 1'b0 : a[n-1];
      end
      4'd9: begin
        s = longint'(a) * longint'(b);
        r = s[15:0]; c = (s >= 65536);
      end
      default: ;
    endcase
  endfunction

  task automatic check_result(input string tag, input logic [3:0] op,
                              input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    logic c, v;
    ref_op(op, a, b, r, c, v);
    chk({tag, "_data"}, 32'(OutputData), 32'(r));
    chk({tag, "_zero"}, 32'(Zero), 32'(r == 16'd0));
    chk({tag, "_neg"},  32'(Negative), 32'(r >= 16'h8000));
    chk({tag, "_carry"}, 32'(Carry), 32'(c));
    chk({tag, "_ovf"},  32'(Overflow), 32'(v));
    chk({tag, "_done"}, 32'(Done), 32'd1);
    chk({tag, "_busy"}, 32'(Busy), 32'd0);
  endtask

  // Called #1 after a rising edge; returns #1 after the edge where Done appears.
  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [15:0] a, input logic [15:0] b, input bit noise);
    int n;
    Start = 1'b1; ALUOp = op; FirstInput = a; SecondInput = b;
    @(posedge CLK); #1;
    Start = 1'b0;
    if (op == 4'd9) begin
      chk({tag, "_busy_start"}, 32'(Busy), 32'd1);
      chk({tag, "_done_early"}, 32'(Done), 32'd0);
      n = 0;
      while (!Done && n < 40) begin
        if (noise) begin
          Start = 1'b1;
          ALUOp = 4'($urandom_range(1, 8));
          FirstInput = 16'($urandom);
          SecondInput = 16'($urandom);
        end
        @(posedge CLK); #1;
        Start = 1'b0;
        n++;
        if (!Done && noise) chk({tag, "_busy_hold"}, 32'(Busy), 32'd1);
      end
      chk({tag, "_latency"}, 32'(n), 32'd16);
    end
    check_result(tag, op, a, b);
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; ALUOp = '0; FirstInput = '0; SecondInput = '0;
    #1;
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_data", 32'(OutputData), 32'd0);
    chk("rst_zero", 32'(Zero), 32'd1);
    chk("rst_carry", 32'(Carry), 32'd0);
    repeat (2) @(posedge CLK);
    #1 Reset = 1'b0;

    // First Start right after reset release; Done is a single-cycle pulse.
    run_op("add_1_1", 4'd1, 16'd1, 16'd1, 1'b0);
    chk("add_1_1_const", 32'(OutputData), 32'd2);
    @(posedge CLK); #1;
    chk("done_pulse_drop", 32'(Done), 32'd0);
    chk("data_hold", 32'(OutputData), 32'd2);

    // Reset in the middle of a MUL clears everything without a clock edge.
    Start = 1'b1; ALUOp = 4'd9; FirstInput = 16'd300; SecondInput = 16'd300;
    @(posedge CLK); #1;
    Start = 1'b0;
    repeat (3) @(posedge CLK);
    #2 Reset = 1'b1;
    #1;
    chk("midmul_rst_busy", 32'(Busy), 32'd0);
    chk("midmul_rst_data", 32'(OutputData), 32'd0);
    chk("midmul_rst_zero", 32'(Zero), 32'd1);
    chk("midmul_rst_done", 32'(Done), 32'd0);
    @(posedge CLK); #1;
    Reset = 1'b0;

    run_op("add_ovf",   4'd1, 16'h7FFF, 16'h0001, 1'b0);
    chk("add_ovf_const", 32'({OutputData, Overflow, Negative}), 32'({16'h8000, 1'b1, 1'b1}));
    run_op("add_carry", 4'd1, 16'hFFFF, 16'h0001, 1'b0);
    chk("add_carry_const", 32'({OutputData, Carry, Zero}), 32'({16'h0000, 1'b1, 1'b1}));
    run_op("sub_neg",   4'd2, 16'd15, 16'd28, 1'b0);
    chk("sub_neg_const", 32'({OutputData, Carry}), 32'({16'hFFF3, 1'b0}));
    run_op("sub_pos",   4'd2, 16'hFFFD, 16'hFFFB, 1'b0);
    run_op("sub_zero",  4'd2, 16'd1, 16'd1, 1'b0);
    run_op("sra",       4'd8, 16'h8001, 16'd1, 1'b0);
    chk("sra_const", 32'({OutputData, Carry}), 32'({16'hC000, 1'b1}));
    run_op("sll",       4'd6, 16'd1, 16'h0013, 1'b0);
    chk("sll_const", 32'(OutputData), 32'd8);
    run_op("srl",       4'd7, 16'h8000, 16'd15, 1'b0);
    chk("srl_const", 32'(OutputData), 32'd1);
    run_op("xor",       4'd5, 16'hA5A5, 16'h0FF0, 1'b0);

    // MUL with Start/operand noise while Busy, then ADD issued in the Done cycle.
    run_op("mul_300", 4'd9, 16'd300, 16'd300, 1'b1);
    chk("mul_300_const", 32'({OutputData, Carry}), 32'({16'h5F90, 1'b1}));
    run_op("b2b_add", 4'd1, 16'd1234, 16'd4321, 1'b0);

    for (int op = 10; op < 16; op++) begin
      run_op("op_unused", 4'(op), 16'($urandom), 16'($urandom), 1'b0);
    end

    for (int i = 0; i < 60; i++) begin
      run_op("rand", 4'($urandom_range(0, 9)), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge CLK); #1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
